// File: rtl/fft_frame_seq.sv
// fft_frame_seq: frame sequencer around a capture FIFO and a streaming FFT core.
// Fills the FIFO, streams one N_PTS frame into the FFT sink with sop/eop framing,
// then collects the result bins and reports the bin index alongside source_valid.
// Optional build macro FFT_FRAME_SEQ_TIMEOUT_EN adds a per-state watchdog that
// aborts a stuck frame back to IDLE with a seq_err pulse.
module fft_frame_seq #(
   parameter int N_PTS       = 4096,
   parameter int CNT_W       = 13,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             cont,
   input  logic             wrfull,
   input  logic             rdempty,
   output logic             wr_fifo_en,
   output logic             rd_fifo_en,
   input  logic             sink_ready,
   output logic             sink_valid,
   output logic             sink_sop,
   output logic             sink_eop,
   input  logic             source_valid,
   input  logic             source_sop,
   input  logic             source_eop,
   output logic [CNT_W-2:0] bin_addr,
   output logic             busy,
   output logic             frame_done,
   output logic             seq_err
);

   typedef enum logic [2:0] {IDLE, CAPTURE, FEED, WAIT_RES, COLLECT, DONE} state_t;

   localparam logic [CNT_W-1:0] FEED_END  = CNT_W'(N_PTS);
   localparam logic [CNT_W-1:0] FEED_LAST = CNT_W'(N_PTS - 1);
   localparam logic [CNT_W-1:0] FEED_ONE  = CNT_W'(1);
   localparam logic [CNT_W-2:0] BIN_LAST  = (CNT_W-1)'(N_PTS - 1);
   localparam logic [CNT_W-2:0] BIN_ONE   = (CNT_W-1)'(1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] feed_cnt;
   logic [CNT_W-2:0] bin_cnt;
   logic             err_nxt;

`ifdef FFT_FRAME_SEQ_TIMEOUT_EN
   localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

   logic [WD_W-1:0] wd_cnt;
   logic            wd_run;
   logic            wd_expired;

   assign wd_run     = (state == CAPTURE) || (state == FEED) ||
                       (state == WAIT_RES) || (state == COLLECT);
   assign wd_expired = wd_run && (wd_cnt == WD_LAST);

   // cycles spent in the current waiting state; restarts on every state change
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt <= '0;
      end else if (!wd_run || (state_nxt != state)) begin
         wd_cnt <= '0;
      end else begin
         wd_cnt <= wd_cnt + WD_W'(1);
      end
   end
`else
   // the watchdog limit has no consumer when the watchdog is not built
   localparam int wd_limit_unused = TIMEOUT_CYC;
`endif

   // next-state decode plus status/enable outputs; rd_fifo_en reacts to ready/empty in-cycle
   always_comb begin
      state_nxt  = state;
      err_nxt    = 1'b0;
      wr_fifo_en = (state == CAPTURE);
      rd_fifo_en = (state == FEED) && sink_ready && !rdempty && (feed_cnt < FEED_END);
      busy       = (state != IDLE);
      frame_done = (state == DONE);
      // a sop beat is always bin 0, whatever the running count says
      bin_addr   = source_sop ? '0 : bin_cnt;
      case (state)
         IDLE:     if (start) state_nxt = CAPTURE;
         CAPTURE:  if (wrfull) state_nxt = FEED;
         FEED:     if (rd_fifo_en && (feed_cnt == FEED_LAST)) state_nxt = WAIT_RES;
         WAIT_RES: begin
            if (source_valid && source_sop) begin
               if (source_eop) begin
                  state_nxt = DONE;
                  err_nxt   = (bin_addr != BIN_LAST);
               end else begin
                  state_nxt = COLLECT;
               end
            end
         end
         COLLECT:  begin
            if (source_valid && source_eop) begin
               state_nxt = DONE;
               err_nxt   = (bin_addr != BIN_LAST);
            end
         end
         DONE:     state_nxt = cont ? CAPTURE : IDLE;
         default:  state_nxt = IDLE;
      endcase
`ifdef FFT_FRAME_SEQ_TIMEOUT_EN
      // a stuck frame is abandoned: no dangling read, back to IDLE with an error pulse
      if (wd_expired) begin
         state_nxt  = IDLE;
         err_nxt    = 1'b1;
         rd_fifo_en = 1'b0;
      end
`endif
   end

   // state register, feed index and result-bin counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         feed_cnt <= '0;
         bin_cnt  <= '0;
         seq_err  <= 1'b0;
      end else begin
         state   <= state_nxt;
         seq_err <= err_nxt;
         if (state != FEED) begin
            feed_cnt <= '0;
         end else if (rd_fifo_en) begin
            feed_cnt <= feed_cnt + FEED_ONE;
         end
         if (state_nxt != COLLECT) begin
            bin_cnt <= '0;
         end else if (source_valid) begin
            bin_cnt <= (bin_addr == BIN_LAST) ? '0 : bin_addr + BIN_ONE;
         end
      end
   end

   // sink framing follows the read request by one clock to line up with FIFO q
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sink_valid <= 1'b0;
         sink_sop   <= 1'b0;
         sink_eop   <= 1'b0;
      end else begin
         sink_valid <= rd_fifo_en;
         sink_sop   <= rd_fifo_en && (feed_cnt == '0);
         sink_eop   <= rd_fifo_en && (feed_cnt == FEED_LAST);
      end
   end

endmodule

// File: tb/tb_fft_frame_seq.sv
// tb_fft_frame_seq: randomized bench for fft_frame_seq with a behavioural FIFO
// and FFT result model. Expected framing, bin indices and status pulses come
// from frame-level counts (N beats per frame, bins 0..N-1, one done per frame).
module tb_fft_frame_seq;
   localparam int N  = 16;
   localparam int CW = 5;
   localparam int TO = 50;

   logic          clk = 1'b0;
   logic          rst_n, start, cont, wrfull, rdempty, sink_ready;
   logic          source_valid, source_sop, source_eop;
   logic          wr_fifo_en, rd_fifo_en, sink_valid, sink_sop, sink_eop;
   logic          busy, frame_done, seq_err;
   logic [CW-2:0] bin_addr;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit v;
      bit sop;
      bit eop;
      int bin;
   } beat_t;

   beat_t plan[$];

   int fifo_cnt, cyc, ready_mode, cont_frames;
   int sink_total, reads, done_cnt, err_cnt, idle_cyc, bad_rd, err_bin, restart_at;
   bit rd_prev, wr_full_prev, no_full;

   always #5 clk = ~clk;

   fft_frame_seq #(.N_PTS(N), .CNT_W(CW), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cont(cont),
      .wrfull(wrfull), .rdempty(rdempty),
      .wr_fifo_en(wr_fifo_en), .rd_fifo_en(rd_fifo_en),
      .sink_ready(sink_ready), .sink_valid(sink_valid),
      .sink_sop(sink_sop), .sink_eop(sink_eop),
      .source_valid(source_valid), .source_sop(source_sop), .source_eop(source_eop),
      .bin_addr(bin_addr), .busy(busy), .frame_done(frame_done), .seq_err(seq_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return 32'({wr_fifo_en, rd_fifo_en, sink_valid, sink_sop, sink_eop,
                  bin_addr, busy, frame_done, seq_err});
   endfunction

   task automatic push_beat(input bit sop, input bit eop, input int bin);
      if ($urandom_range(0, 3) == 0) plan.push_back('{0, 0, 0, 0});
      plan.push_back('{1, sop, eop, bin});
   endtask

   // FFT result model: latency, optional aborted partial frame, then bins 0..last
   task automatic build_plan();
      int last;
      last = (err_bin >= 0) ? err_bin : N - 1;
      repeat ($urandom_range(1, 4)) plan.push_back('{0, 0, 0, 0});
      if (restart_at >= 0)
         for (int i = 0; i < restart_at; i++) push_beat(i == 0, 1'b0, i);
      for (int i = 0; i <= last; i++) push_beat(i == 0, i == last, i);
   endtask

   // one clock: drive at negedge, sample 1ns later, advance the environment model
   task automatic cycle(input bit st);
      beat_t e;
      @(negedge clk);
      cyc++;
      start   = st;
      cont    = (done_cnt < cont_frames - 1);
      wrfull  = no_full ? 1'b0 : (fifo_cnt >= N);
      rdempty = (fifo_cnt == 0) || (ready_mode == 2 && $urandom_range(0, 3) == 0);
      case (ready_mode)
         1:       sink_ready = (cyc % 3 != 0);
         2:       sink_ready = ($urandom_range(0, 2) != 0);
         default: sink_ready = 1'b1;
      endcase
      e = '{0, 0, 0, 0};
      if (plan.size() > 0) e = plan.pop_front();
      source_valid = e.v;
      source_sop   = e.sop;
      source_eop   = e.eop;
      #1;
      if (rd_fifo_en && !sink_ready) bad_rd++;
      chk("sink_valid_lat", sink_valid, rd_prev);
      if (sink_valid) begin
         chk("sink_sop", sink_sop, (sink_total % N) == 0);
         chk("sink_eop", sink_eop, (sink_total % N) == N - 1);
         sink_total++;
         if (sink_eop) build_plan();
      end
      if (wr_full_prev) chk("wr_drop_after_full", wr_fifo_en, 0);
      wr_full_prev = wr_fifo_en && wrfull;
      if (wr_fifo_en && !wrfull && !no_full) fifo_cnt++;
      if (rd_fifo_en) begin
         fifo_cnt--;
         reads++;
      end
      rd_prev = rd_fifo_en;
      if (e.v) chk("bin_addr", bin_addr, e.bin);
      if (frame_done) done_cnt++;
      if (seq_err) err_cnt++;
      if (!busy) idle_cyc++;
   endtask

   task automatic run_frames(input string tag, input int nf, input int rmode,
                             input int ebin, input int rst_at, input int exp_err);
      int budget;
      ready_mode  = rmode;
      err_bin     = ebin;
      restart_at  = rst_at;
      cont_frames = nf;
      done_cnt = 0; err_cnt = 0; bad_rd = 0; sink_total = 0; reads = 0;
      cycle(1'b1);
      idle_cyc = 0;
      budget   = 0;
      while (done_cnt < nf && budget < 400 * nf) begin
         // stray start pulses while busy must be ignored
         cycle(busy && ($urandom_range(0, 19) == 0));
         budget++;
      end
      chk({tag, "_in_budget"}, budget < 400 * nf, 1);
      chk({tag, "_frame_done"}, done_cnt, nf);
      chk({tag, "_seq_err"}, err_cnt, exp_err);
      chk({tag, "_no_idle"}, idle_cyc, 0);
      chk({tag, "_sink_beats"}, sink_total, N * nf);
      chk({tag, "_reads"}, reads, N * nf);
      chk({tag, "_rd_wo_ready"}, bad_rd, 0);
      cycle(1'b0);
      chk({tag, "_busy_end"}, busy, 0);
      chk({tag, "_pulses_end"}, {frame_done, seq_err}, 0);
   endtask

   initial begin
      int budget;
      int cap;
      rst_n = 1'b0; start = 1'b0; cont = 1'b0; wrfull = 1'b0; rdempty = 1'b1;
      sink_ready = 1'b0; source_valid = 1'b0; source_sop = 1'b0; source_eop = 1'b0;
      err_bin = -1; restart_at = -1; cont_frames = 1;
      repeat (2) @(negedge clk);
      chk("reset_outs", outs(), 0);
      rst_n = 1'b1;

      run_frames("single", 1, 0, -1, -1, 0);
      run_frames("ready_every3", 1, 1, -1, -1, 0);
      run_frames("cont3", 3, 0, -1, -1, 0);
      run_frames("early_eop9", 1, 0, 9, -1, 1);
      run_frames("sop_restart", 1, 2, -1, 5, 0);
      for (int k = 0; k < 4; k++) begin
         int nf;
         int eb;
         nf = $urandom_range(1, 2);
         eb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 14)) : -1;
         run_frames("rand", nf, $urandom_range(0, 2), eb, -1, (eb >= 0) ? nf : 0);
      end

      // reset in the middle of FEED with cont held high
      ready_mode = 0; err_bin = -1; restart_at = -1; cont_frames = 100;
      done_cnt = 0; reads = 0; sink_total = 0;
      cycle(1'b1);
      budget = 0;
      while (reads < 7 && budget < 200) begin
         cycle(1'b0);
         budget++;
      end
      chk("rst_reach_feed7", reads, 7);
      #1 rst_n = 1'b0;
      #1 chk("rst_async_outs", outs(), 0);
      fifo_cnt = 0; rd_prev = 1'b0; wr_full_prev = 1'b0; plan.delete();
      sink_total = 0; done_cnt = 0; err_cnt = 0;
      repeat (2) cycle(1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      idle_cyc = 0;
      repeat (30) cycle(1'b0);
      chk("rst_stay_idle", idle_cyc, 30);
      chk("rst_no_done", done_cnt, 0);
      chk("rst_no_writes", fifo_cnt, 0);

      run_frames("after_reset", 1, 0, -1, -1, 0);

      // FIFO never reports full
      no_full = 1'b1; ready_mode = 0; cont_frames = 1; err_cnt = 0; cap = 0;
      cycle(1'b1);
`ifdef FFT_FRAME_SEQ_TIMEOUT_EN
      budget = 0;
      while (err_cnt == 0 && budget < 100) begin
         cycle(1'b0);
         budget++;
         if (wr_fifo_en) cap++;
      end
      chk("wd_capture_cycles", cap, TO);
      chk("wd_seq_err", err_cnt, 1);
      chk("wd_wr_dropped", wr_fifo_en, 0);
      chk("wd_idle", busy, 0);
`else
      repeat (TO + 10) begin
         cycle(1'b0);
         if (wr_fifo_en) cap++;
      end
      chk("nowd_capture_cycles", cap, TO + 10);
      chk("nowd_seq_err", err_cnt, 0);
      chk("nowd_busy", busy, 1);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/fft_frame_seq.md
FFT_FRAME_SEQ -- requirements
Module: fft_frame_seq

Interface
REQ-001 SHALL have parameter N_PTS, default 4096, FFT frame length in samples.
REQ-002 SHALL have parameter CNT_W, default 13, counter width (holds 0..N_PTS).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1000000, watchdog limit in clk cycles.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to run one frame.
REQ-007 SHALL have port cont  input  1  continuous mode; sampled in DONE.
REQ-008 SHALL have port wrfull, rdempty  input  1 each  FIFO status flags.
REQ-009 SHALL have port wr_fifo_en, rd_fifo_en  output  1 each  FIFO write enable (level) and read request.
REQ-010 SHALL have port sink_ready  input  1  FFT input ready.
REQ-011 SHALL have port sink_valid, sink_sop, sink_eop  output  1 each  FFT input framing.
REQ-012 SHALL have port source_valid, source_sop, source_eop  input  1 each  FFT output framing.
REQ-013 SHALL have port bin_addr  output  CNT_W-1  index of current output bin, valid with source_valid.
REQ-014 SHALL have port busy, frame_done, seq_err  output  1 each  status; frame_done and seq_err are one-cycle pulses.

Function
REQ-015 SHALL implement states IDLE, CAPTURE, FEED, WAIT_RES, COLLECT, DONE.
REQ-016 IDLE: start=1 -> CAPTURE; start in any other state SHALL be ignored.
REQ-017 CAPTURE: wr_fifo_en=1; wrfull=1 -> wr_fifo_en=0 next cycle, -> FEED.
REQ-018 FEED: rd_fifo_en = sink_ready & !rdempty & (feed_cnt < N_PTS); feed_cnt increments per asserted rd_fifo_en.
REQ-019 sink_valid SHALL be rd_fifo_en delayed one clk (FIFO q latency 1); sink_sop with the beat of feed index 0, sink_eop with index N_PTS-1.
REQ-020 rdempty=1 or sink_ready=0 mid-FEED SHALL stall reads with no beat lost, duplicated or reordered.
REQ-021 FEED -> WAIT_RES in the cycle after the eop beat is issued.
REQ-022 WAIT_RES: source_valid & source_sop -> COLLECT, that beat counted as bin 0.
REQ-023 COLLECT: bin_addr increments per source_valid beat, wraps to 0 after N_PTS-1; source_valid & source_eop -> DONE.
REQ-024 source_eop arriving at bin count != N_PTS-1 SHALL pulse seq_err and still go to DONE.
REQ-025 source_sop while in COLLECT SHALL restart bin_addr at 0 (new frame), no error.
REQ-026 DONE: frame_done=1 one cycle; cont=1 -> CAPTURE, else -> IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 FIFO reads and FFT result collection SHALL NOT overlap: CAPTURE for frame k+1 begins only after DONE of frame k.

Reset
REQ-029 rst_n=0 SHALL asynchronously force IDLE, all counters 0, all outputs 0.
REQ-030 Reset mid-frame SHALL abandon the frame; no frame_done pulse; partially fed FFT frame is discarded by reset of the FFT core on the same rst_n.
REQ-031 After release, first action SHALL require a new start pulse regardless of cont.

Configuration
REQ-032 Macro FFT_FRAME_SEQ_TIMEOUT_EN defined: a watchdog counter runs in CAPTURE, FEED, WAIT_RES, COLLECT, clears on every state change; reaching TIMEOUT_CYC SHALL pulse seq_err, drop all enables, and go to IDLE.
REQ-033 Macro undefined: no watchdog logic; states wait indefinitely; seq_err driven only by REQ-024.

Verification
REQ-034 N_PTS=16, start pulse, wrfull after 16 writes, sink_ready=1, FFT model returns 16 beats -> 16 sink beats, sop at 0, eop at 15, bin_addr 0..15, one frame_done, busy back to 0.
REQ-035 Same, sink_ready toggled 0 every 3rd cycle in FEED -> still exactly 16 sink_valid beats, data order preserved, rd_fifo_en never high with sink_ready=0.
REQ-036 cont=1, three frames -> three frame_done pulses, CAPTURE re-entered directly from DONE each time, no IDLE visit.
REQ-037 FFT model asserts source_eop at bin 9 of 16 -> seq_err one cycle, frame_done one cycle, return to IDLE.
REQ-038 rst_n asserted at feed index 7 -> all outputs 0 asynchronously, IDLE; cont=1 held, no activity until next start.
REQ-039 With FFT_FRAME_SEQ_TIMEOUT_EN, TIMEOUT_CYC=50, wrfull never asserts -> seq_err at cycle 50 of CAPTURE, wr_fifo_en=0, IDLE; without macro -> stays in CAPTURE.
